wb_dbg_master: RTL and testbench

Byte-stream-to-Wishbone debug initiator. It turns command bytes from a host link (normally the UART receive path) into single 32-bit Wishbone read/write cycles. It returns status and read data as bytes on the transmit stream. It attaches to a free master port of `wb_conbus_top` (m2), so a host can peek and poke BRAM, DDR and peripherals while the LM32 runs.

---
 rtl/wb_dbg_pkg.sv | 25 ++
 rtl/wb_dbg_master.sv | 170 +++++++++++++++++
 tb/tb_wb_dbg_master.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dbg_pkg.sv
// ============================================================================
// wb_dbg_pkg : command/status codes and FSM states for the Wishbone debug master
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_dbg_pkg;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ST_OK  = 8'hA5;
  localparam logic [7:0] ST_ERR = 8'hEE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    BUS    = 3'd3,
    STATUS = 3'd4,
    RDATA  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_dbg_master.sv
// ============================================================================
// wb_dbg_master : byte-stream to single-cycle Wishbone debug initiator
// Optional bus timeout enabled by defining WB_DBG_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_dbg_master
  import wb_dbg_pkg::*;
#(
  parameter int timeout_cycles = 1024,
  parameter int tcnt_width     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_dat,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_dat,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy
);

  state_t      state;
  logic [1:0]  cnt;
  logic        is_rd;
  logic        ok;
  logic [31:0] rdat;
  logic        accept;
  logic        tmo;
  logic        term;

  assign accept = rx_valid && rx_ready;

`ifdef WB_DBG_TIMEOUT_EN
  logic [tcnt_width-1:0] tcnt;

  // Held at zero outside BUS, so it restarts on every bus cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != BUS)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  assign tmo = (tcnt == tcnt_width'(timeout_cycles - 1));
`else
  assign tmo = 1'b0;
`endif

  assign term = wb_ack_i || wb_err_i || wb_rty_i || tmo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      is_rd    <= 1'b0;
      ok       <= 1'b0;
      rdat     <= 32'h0;
      rx_ready <= 1'b0;
      tx_dat   <= 8'h00;
      tx_valid <= 1'b0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      wb_sel_o <= 4'h0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (accept && (rx_dat == CMD_WR || rx_dat == CMD_RD)) begin
            is_rd <= (rx_dat == CMD_RD);
            cnt   <= 2'd0;
            busy  <= 1'b1;
            state <= ADDR;
          end
        end

        ADDR: if (accept) begin
          wb_adr_o <= {wb_adr_o[23:0], rx_dat};
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (is_rd) begin
              rx_ready <= 1'b0;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_sel_o <= 4'hF;
              wb_we_o  <= 1'b0;
              state    <= BUS;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: if (accept) begin
          wb_dat_o <= {wb_dat_o[23:0], rx_dat};
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            rx_ready <= 1'b0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_sel_o <= 4'hF;
            wb_we_o  <= 1'b1;
            state    <= BUS;
          end
        end

        // ack wins over every other termination, so only it reports OK.
        BUS: if (term) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_sel_o <= 4'h0;
          ok       <= wb_ack_i;
          tx_dat   <= wb_ack_i ? ST_OK : ST_ERR;
          tx_valid <= 1'b1;
          if (wb_ack_i)
            rdat <= wb_dat_i;
          state    <= STATUS;
        end

        STATUS: if (tx_ready) begin
          if (is_rd && ok) begin
            tx_dat <= rdat[31:24];
            rdat   <= {rdat[23:0], 8'h00};
            cnt    <= 2'd0;
            state  <= RDATA;
          end else begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        RDATA: if (tx_ready) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            tx_dat <= rdat[31:24];
            rdat   <= {rdat[23:0], 8'h00};
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_dbg_master.sv
// ============================================================================
// tb_wb_dbg_master : directed self-checking bench for wb_dbg_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_dbg_master;
  import wb_dbg_pkg::*;

`ifdef WB_DBG_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_dat;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        busy;

  int vectors = 0;
  int errors  = 0;
  int mode    = 0;  // 0 ack, 1 err, 2 rty, 3 ack+err, 4 silent

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  wb_dbg_master #(.timeout_cycles(TMO), .tcnt_width(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .busy(busy)
  );

  // Zero-wait BRAM-style slave with selectable termination behaviour.
  always_comb begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = mem[wb_adr_o[9:2]];
    if (wb_cyc_o && wb_stb_o) begin
      case (mode)
        0: wb_ack_i = 1'b1;
        1: wb_err_i = 1'b1;
        2: wb_rty_i = 1'b1;
        3: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hCAFEF00D; end
        default: ;
      endcase
    end
  end

  always @(posedge clk)
    if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i)
      mem[wb_adr_o[9:2]] <= wb_dat_o;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_dat   = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      vectors++;
      errors++;
      $display("FAIL rx_accept: rx_ready=%b required 1", rx_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr,
                          input logic [31:0] dat, input bit wr);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
    if (wr)
      for (int i = 0; i < 4; i++) send_byte(dat[31-8*i -: 8]);
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit got);
    int n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    got = tx_valid;
    b   = tx_dat;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tx_valid, rx_ready, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b sel=%h txv=%b rxr=%b busy=%b required all 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tx_valid, rx_ready, busy);
    end
    vectors++;
    if ({wb_adr_o, wb_dat_o, tx_dat} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data: adr=%h dat=%h tx_dat=%h required 0", wb_adr_o, wb_dat_o, tx_dat);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rx_ready=%b busy=%b required 1 0", rx_ready, busy);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] b;
    bit         got;
    logic [7:0] exp [5] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mode = 0;
    send_cmd(CMD_WR, 32'h0000_0100, 32'hDEADBEEF, 1'b1);
    vectors++;
    if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || wb_sel_o !== 4'hF ||
        wb_adr_o !== 32'h100 || wb_dat_o !== 32'hDEADBEEF || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_bus: cyc=%b we=%b sel=%h adr=%h dat=%h txv=%b required 1 1 f 100 deadbeef 0",
               wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, tx_valid);
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1 || tx_dat !== ST_OK || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_turnaround: txv=%b tx_dat=%h cyc=%b stb=%b required 1 a5 0 0",
               tx_valid, tx_dat, wb_cyc_o, wb_stb_o);
    end
    recv_byte(b, got);
    vectors++;
    if (!got || b !== 8'hA5) begin
      errors++;
      $display("FAIL wr_status: got=%b byte=%h required a5", got, b);
    end
    vectors++;
    if (mem[64] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_mem: mem=%h required deadbeef", mem[64]);
    end
    send_cmd(CMD_RD, 32'h0000_0100, 32'h0, 1'b0);
    vectors++;
    if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b0 || wb_adr_o !== 32'h100 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_bus: cyc=%b we=%b adr=%h rxr=%b required 1 0 100 0",
               wb_cyc_o, wb_we_o, wb_adr_o, rx_ready);
    end
    for (int i = 0; i < 5; i++) begin
      recv_byte(b, got);
      vectors++;
      if (!got || b !== exp[i]) begin
        errors++;
        $display("FAIL rd_byte%0d: got=%b byte=%h required %h", i, got, b, exp[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: busy=%b txv=%b required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_err();
    logic [7:0] b;
    bit         got;
    int         extra = 0;
    mode = 1;
    send_cmd(CMD_RD, 32'h0000_0200, 32'h0, 1'b0);
    recv_byte(b, got);
    vectors++;
    if (!got || b !== ST_ERR) begin
      errors++;
      $display("FAIL err_status: got=%b byte=%h required ee", got, b);
    end
    tx_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) extra++;
    end
    tx_ready = 1'b0;
    vectors++;
    if (extra != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_nodata: extra_bytes=%0d busy=%b required 0 0", extra, busy);
    end
  endtask

  task automatic test_rty();
    logic [7:0] b;
    bit         got;
    mode = 2;
    send_cmd(CMD_WR, 32'h0000_0300, 32'h0000_0001, 1'b1);
    recv_byte(b, got);
    vectors++;
    if (!got || b !== ST_ERR || mem[192] !== 32'h0) begin
      errors++;
      $display("FAIL rty_status: got=%b byte=%h mem=%h required ee 0", got, b, mem[192]);
    end
  endtask

  task automatic test_ack_err();
    logic [7:0] b;
    bit         got;
    logic [7:0] exp [5] = '{8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    mode = 3;
    send_cmd(CMD_RD, 32'h0000_0100, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      recv_byte(b, got);
      vectors++;
      if (!got || b !== exp[i]) begin
        errors++;
        $display("FAIL ackerr_byte%0d: got=%b byte=%h required %h", i, got, b, exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef WB_DBG_TIMEOUT_EN
    logic [7:0] b;
    bit         got;
    int         n = 0;
    mode = 4;
    send_cmd(CMD_RD, 32'h0000_0400, 32'h0, 1'b0);
    while (wb_cyc_o && n < 2000) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 8) begin
      errors++;
      $display("FAIL tmo_cycles: cyc_high=%0d required 8", n);
    end
    recv_byte(b, got);
    vectors++;
    if (!got || b !== ST_ERR) begin
      errors++;
      $display("FAIL tmo_status: got=%b byte=%h required ee", got, b);
    end
`else
    mode = 4;
    send_cmd(CMD_RD, 32'h0000_0400, 32'h0, 1'b0);
    repeat (1000) @(negedge clk);
    vectors++;
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL notmo_wait: cyc=%b stb=%b txv=%b required 1 1 0", wb_cyc_o, wb_stb_o, tx_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    bit         got;
    int         bad = 0;
    logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mode = 0;
    send_cmd(CMD_RD, 32'h0000_0100, 32'h0, 1'b0);
    recv_byte(b, got);
    vectors++;
    if (!got || b !== ST_OK) begin
      errors++;
      $display("FAIL bp_status: got=%b byte=%h required a5", got, b);
    end
    repeat (20) begin
      @(negedge clk);
      if (tx_dat !== 8'hDE || tx_valid !== 1'b1 || rx_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: unstable_cycles=%0d required 0 (tx_dat=%h)", bad, tx_dat);
    end
    for (int i = 0; i < 4; i++) begin
      recv_byte(b, got);
      vectors++;
      if (!got || b !== exp[i]) begin
        errors++;
        $display("FAIL bp_byte%0d: got=%b byte=%h required %h", i, got, b, exp[i]);
      end
    end
  endtask

  task automatic test_invalid();
    int extra = 0;
    send_byte(8'h7F);
    rx_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_idle: busy=%b rx_ready=%b required 0 1", busy, rx_ready);
    end
    tx_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid || busy) extra++;
    end
    tx_ready = 1'b0;
    vectors++;
    if (extra != 0) begin
      errors++;
      $display("FAIL inv_silent: active_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    bit         got;
    int         extra = 0;
    mode = 4;
    send_cmd(CMD_RD, 32'h0000_0100, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: cyc=%b required 1", wb_cyc_o);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_drop: cyc=%b stb=%b txv=%b busy=%b required 0 0 0 0",
               wb_cyc_o, wb_stb_o, tx_valid, busy);
    end
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx_valid) extra++;
    end
    tx_ready = 1'b0;
    vectors++;
    if (extra != 0) begin
      errors++;
      $display("FAIL mid_silent: tx_cycles=%0d required 0", extra);
    end
    mode = 0;
    send_cmd(CMD_WR, 32'h0000_0104, 32'h11223344, 1'b1);
    recv_byte(b, got);
    vectors++;
    if (!got || b !== ST_OK || mem[65] !== 32'h11223344) begin
      errors++;
      $display("FAIL mid_recover: got=%b byte=%h mem=%h required a5 11223344", got, b, mem[65]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_err();
    test_rty();
    test_ack_err();
    test_timeout();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
